// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the ROM byte address and hands {instr, pc} to decode.
// Optional zero-word trap output instr_illegal is enabled by defining FETCH_ZERO_TRAP_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_fault,
  output logic              fetch_busy,
  output logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       rom_data
`ifdef FETCH_ZERO_TRAP_EN
  ,
  output logic              instr_illegal
`endif
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_VALID = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  logic [2:0]        state_r,       state_s;
  logic [31:0]       pc_r,          pc_s;
  logic [ADDR_W-1:0] i_addr_r,      i_addr_s;
  logic [31:0]       instr_r,       instr_s;
  logic [31:0]       instr_pc_r,    instr_pc_s;
  logic              instr_valid_r, instr_valid_s;
  logic              instr_fault_r, instr_fault_s;
  logic              fetch_busy_r,  fetch_busy_s;
  logic [31:0]       pc_inc_s;
`ifdef FETCH_ZERO_TRAP_EN
  logic              illegal_r,     illegal_s;
`endif

  assign pc_inc_s = pc_r + 32'd4;

  // Next-state and next-output logic; a redirect pre-empts everything the FSM would otherwise do.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    i_addr_s      = i_addr_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    instr_fault_s = instr_fault_r;
`ifdef FETCH_ZERO_TRAP_EN
    illegal_s     = illegal_r;
`endif
    if (redirect_valid) begin
      instr_valid_s = 1'b0;
      pc_s          = redirect_pc;
`ifdef FETCH_ZERO_TRAP_EN
      illegal_s     = 1'b0;
`endif
      if (redirect_pc[1:0] == 2'b00) begin
        instr_fault_s = 1'b0;
        state_s       = ST_IDLE;
      end else begin
        instr_fault_s = 1'b1;
        instr_pc_s    = redirect_pc;
        state_s       = ST_FAULT;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fetch_en) begin
            i_addr_s = pc_r[ADDR_W-1:0];
            state_s  = ST_WAIT;
          end else begin
            state_s  = ST_IDLE;
          end
        end
        ST_WAIT: begin
          state_s = ST_DATA;
        end
        ST_DATA: begin
          instr_s       = rom_data;
          instr_pc_s    = pc_r;
          instr_valid_s = 1'b1;
`ifdef FETCH_ZERO_TRAP_EN
          illegal_s     = (rom_data == 32'h0000_0000);
`endif
          state_s       = ST_VALID;
        end
        ST_VALID: begin
          if (instr_ready) begin
            pc_s          = pc_inc_s;
            instr_valid_s = 1'b0;
`ifdef FETCH_ZERO_TRAP_EN
            illegal_s     = 1'b0;
`endif
            if (fetch_en) begin
              i_addr_s = pc_inc_s[ADDR_W-1:0];
              state_s  = ST_WAIT;
            end else begin
              state_s  = ST_IDLE;
            end
          end else begin
            state_s = ST_VALID;
          end
        end
        ST_FAULT: begin
          state_s = ST_FAULT;
        end
        default: begin
          state_s       = ST_IDLE;
          instr_valid_s = 1'b0;
        end
      endcase
    end
    fetch_busy_s = (state_s == ST_WAIT) || (state_s == ST_DATA);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_PC;
      i_addr_r      <= {ADDR_W{1'b0}};
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      instr_valid_r <= 1'b0;
      instr_fault_r <= 1'b0;
      fetch_busy_r  <= 1'b0;
`ifdef FETCH_ZERO_TRAP_EN
      illegal_r     <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      i_addr_r      <= i_addr_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      instr_fault_r <= instr_fault_s;
      fetch_busy_r  <= fetch_busy_s;
`ifdef FETCH_ZERO_TRAP_EN
      illegal_r     <= illegal_s;
`endif
    end
  end

  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_fault = instr_fault_r;
  assign fetch_busy  = fetch_busy_r;
  assign i_addr      = i_addr_r;
`ifdef FETCH_ZERO_TRAP_EN
  assign instr_illegal = illegal_r;
`endif

endmodule
